// File: rtl/sd_pkg.sv
// Shared types and helpers for the SD block cache.
package sd_pkg;

    localparam int unsigned BlockBytes    = 512;
    localparam int unsigned WordsPerBlock = 128;
    localparam int unsigned TagWidth      = 23;
    localparam int unsigned IdxWidth      = 7;
    localparam int unsigned AddrWidth     = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_FILL,
        ST_RESPOND,
        ST_FLUSH
    } state_t;

    // SDSC cards take byte addresses; SDHC cards take block numbers.
    function automatic logic [AddrWidth-1:0] sd_addr_f(input logic [TagWidth-1:0] tag,
                                                       input logic                sdsc);
        logic [AddrWidth-1:0] a;
        if (sdsc) a = {tag, 9'b0};
        else      a = {9'b0, tag};
        return a;
    endfunction

endpackage

// File: rtl/sd_block_cache.sv
// Single-line write-back block buffer between a 32-bit Wishbone CPU bus and a
// 512-byte SD block controller.
module sd_block_cache #(
    parameter bit          SDSC       = 1'b0,
    parameter int unsigned BLOCK_BITS = 4096
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_cyc,
    input  logic                  cpu_stb,
    input  logic                  cpu_we,
    input  logic [3:0]            cpu_sel,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_dat_i,
    output logic [31:0]           cpu_dat_o,
    output logic                  cpu_ack,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  sd_cyc,
    output logic                  sd_stb,
    output logic                  sd_we,
    output logic [31:0]           sd_addr,
    output logic [BLOCK_BITS-1:0] sd_dat_o,
    input  logic [BLOCK_BITS-1:0] sd_dat_i,
    input  logic                  sd_ack
);
    import sd_pkg::*;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_valid;
    logic                    r_dirty;
    logic [TagWidth-1:0]     r_tag;
    logic [TagWidth-1:0]     r_miss_tag;
    logic [BLOCK_BITS-1:0]   r_line;
    logic                    r_cpu_ack;
    logic [31:0]             r_cpu_dat_o;
    logic                    r_flush_done;
    logic                    r_sd_stb;
    logic                    r_sd_we;
    logic [AddrWidth-1:0]    r_sd_addr;

    logic [TagWidth-1:0]     w_cpu_tag;
    logic [IdxWidth-1:0]     w_idx;
    logic                    w_req;
    logic                    w_hit;
    logic [TagWidth-1:0]     w_miss_tag;
    logic                    w_wb_done;
    logic                    w_fill_done;
    logic                    w_respond;
    logic                    w_flush_clean;
    logic                    w_flush_done;
    logic                    w_sd_req;
    logic                    w_sd_we;
    logic [AddrWidth-1:0]    w_sd_addr;
    logic                    w_unused_addr;

    assign w_cpu_tag     = cpu_addr[31:9];
    assign w_idx         = cpu_addr[8:2];
    assign w_unused_addr = &{1'b0, cpu_addr[1:0]};
    // The CPU drops stb on the edge after ack, so a request seen while ack is
    // still high is the one just served.
    assign w_req         = cpu_cyc && cpu_stb && !r_cpu_ack;
    assign w_hit         = r_valid && (r_tag == w_cpu_tag);
    assign w_miss_tag    = (r_state == ST_IDLE) ? w_cpu_tag : r_miss_tag;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state, datapath strobes and the SD request for the coming cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_wb_done     = 1'b0;
        w_fill_done   = 1'b0;
        w_respond     = 1'b0;
        w_flush_clean = 1'b0;
        w_flush_done  = 1'b0;
        w_sd_req      = 1'b0;
        w_sd_we       = 1'b0;
        w_sd_addr     = r_sd_addr;

        case (r_state)
            ST_IDLE: begin
                if (flush) begin
                    if (r_dirty) w_state_nxt = ST_FLUSH;
                    else         w_flush_clean = 1'b1;
                end else if (w_req) begin
                    if (w_hit)        w_state_nxt = ST_RESPOND;
                    else if (r_dirty) w_state_nxt = ST_WRITEBACK;
                    else              w_state_nxt = ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                if (sd_ack) begin
                    w_wb_done   = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FLUSH: begin
                if (sd_ack) begin
                    w_wb_done    = 1'b1;
                    w_flush_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (sd_ack) begin
                    w_fill_done = 1'b1;
                    // Only answer if the CPU is still asking for the installed block.
                    if (cpu_cyc && cpu_stb && (w_cpu_tag == r_miss_tag))
                        w_state_nxt = ST_RESPOND;
                    else
                        w_state_nxt = ST_IDLE;
                end
            end
            ST_RESPOND: begin
                w_respond   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // The cycle that consumes sd_ack always drops the request for one cycle.
        case (w_state_nxt)
            ST_WRITEBACK, ST_FLUSH: begin
                w_sd_req  = !(w_wb_done || w_fill_done);
                w_sd_we   = 1'b1;
                w_sd_addr = sd_addr_f(r_tag, SDSC);
            end
            ST_FILL: begin
                w_sd_req  = !(w_wb_done || w_fill_done);
                w_sd_addr = sd_addr_f(w_miss_tag, SDSC);
            end
            default: ;
        endcase
    end

    // Line storage, tag/valid/dirty bookkeeping and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= 1'b0;
            r_dirty      <= 1'b0;
            r_tag        <= '0;
            r_miss_tag   <= '0;
            r_line       <= '0;
            r_cpu_ack    <= 1'b0;
            r_cpu_dat_o  <= '0;
            r_flush_done <= 1'b0;
            r_sd_stb     <= 1'b0;
            r_sd_we      <= 1'b0;
            r_sd_addr    <= '0;
        end else begin
            r_cpu_ack    <= w_respond;
            r_flush_done <= w_flush_clean || w_flush_done;
            r_sd_stb     <= w_sd_req;
            r_sd_we      <= w_sd_req && w_sd_we;
            if (w_sd_req) r_sd_addr <= w_sd_addr;

            if ((r_state == ST_IDLE) && w_req) r_miss_tag <= w_cpu_tag;

            if (w_wb_done) r_dirty <= 1'b0;

            if (w_fill_done) begin
                r_line  <= sd_dat_i;
                r_tag   <= r_miss_tag;
                r_valid <= 1'b1;
                r_dirty <= 1'b0;
            end

            if (w_respond) begin
                if (cpu_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (cpu_sel[b])
                            r_line[{w_idx, 2'(b), 3'b000} +: 8] <= cpu_dat_i[8*b +: 8];
                    end
                    r_dirty <= 1'b1;
                end else begin
                    r_cpu_dat_o <= r_line[{w_idx, 5'b00000} +: 32];
                end
            end
        end
    end

    assign cpu_ack    = r_cpu_ack;
    assign cpu_dat_o  = r_cpu_dat_o;
    assign flush_done = r_flush_done;
    assign sd_cyc     = r_sd_stb;
    assign sd_stb     = r_sd_stb;
    assign sd_we      = r_sd_we;
    assign sd_addr    = r_sd_addr;
    assign sd_dat_o   = r_line;

endmodule

// File: tb/tb_sd_block_cache.sv
// Directed bench for sd_block_cache: an SD card model answers block requests
// and checks them against expected transactions queued by the stimulus.
module tb_sd_block_cache;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic        chk_word;
        logic [6:0]  idx;
        logic [31:0] word;
    } sd_exp_t;

    logic clk = 1'b0;
    logic reset_n;

    logic          cpu_cyc, cpu_stb, cpu_we, flush;
    logic [3:0]    cpu_sel;
    logic [31:0]   cpu_addr, cpu_dat_i, cpu_dat_o;
    logic          cpu_ack, flush_done;
    logic          sd_cyc, sd_stb, sd_we;
    logic [31:0]   sd_addr;
    logic [4095:0] sd_dat_o;
    logic [4095:0] sd_dat_i = '0;
    logic          sd_ack = 1'b0;

    logic          cpu1_cyc, cpu1_stb, cpu1_we, flush1;
    logic [3:0]    cpu1_sel;
    logic [31:0]   cpu1_addr, cpu1_dat_i, cpu1_dat_o;
    logic          cpu1_ack, flush1_done;
    logic          sd1_cyc, sd1_stb, sd1_we;
    logic [31:0]   sd1_addr;
    logic [4095:0] sd1_dat_o;
    logic [4095:0] sd1_dat_i = '0;
    logic          sd1_ack = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int sd_lat = 2;
    int sd_cnt = 0;
    int sd1_cnt = 0;

    logic [4095:0] mem [logic [31:0]];
    sd_exp_t       sd_exp_q[$];
    logic [31:0]   sd1_exp_q[$];
    logic [31:0]   rd_q[$];

    sd_block_cache #(.SDSC(1'b0), .BLOCK_BITS(4096)) u_dut (
        .clock(clk), .reset_n(reset_n),
        .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
        .cpu_addr(cpu_addr), .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o), .cpu_ack(cpu_ack),
        .flush(flush), .flush_done(flush_done),
        .sd_cyc(sd_cyc), .sd_stb(sd_stb), .sd_we(sd_we), .sd_addr(sd_addr),
        .sd_dat_o(sd_dat_o), .sd_dat_i(sd_dat_i), .sd_ack(sd_ack)
    );

    sd_block_cache #(.SDSC(1'b1), .BLOCK_BITS(4096)) u_dut_sdsc (
        .clock(clk), .reset_n(reset_n),
        .cpu_cyc(cpu1_cyc), .cpu_stb(cpu1_stb), .cpu_we(cpu1_we), .cpu_sel(cpu1_sel),
        .cpu_addr(cpu1_addr), .cpu_dat_i(cpu1_dat_i), .cpu_dat_o(cpu1_dat_o), .cpu_ack(cpu1_ack),
        .flush(flush1), .flush_done(flush1_done),
        .sd_cyc(sd1_cyc), .sd_stb(sd1_stb), .sd_we(sd1_we), .sd_addr(sd1_addr),
        .sd_dat_o(sd1_dat_o), .sd_dat_i(sd1_dat_i), .sd_ack(sd1_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [4095:0] make_block(input logic [31:0] a);
        logic [4095:0] b;
        for (int i = 0; i < 128; i++) b[32*i +: 32] = {8'hC0, a[7:0], 8'h00, 8'(i)};
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_sd(input logic we, input logic [31:0] addr, input logic cw,
                          input logic [6:0] idx, input logic [31:0] word);
        sd_exp_t e;
        e.we = we; e.addr = addr; e.chk_word = cw; e.idx = idx; e.word = word;
        sd_exp_q.push_back(e);
    endtask

    // SD card model for the SDHC instance: acks after sd_lat cycles of stb.
    always @(negedge clk) begin
        sd_exp_t e;
        if (!reset_n) begin
            sd_ack = 1'b0;
            sd_cnt = 0;
        end else if (sd_ack) begin
            sd_ack = 1'b0;
            chk("sd_stb_drop", 32'(sd_stb), 32'd0);
        end else if (sd_cyc && sd_stb) begin
            sd_cnt++;
            if (sd_cnt >= sd_lat) begin
                sd_cnt = 0;
                if (sd_exp_q.size() == 0) begin
                    chk("sd_unexpected_txn", sd_addr, 32'hFFFF_FFFF);
                end else begin
                    e = sd_exp_q.pop_front();
                    chk("sd_we", 32'(sd_we), 32'(e.we));
                    chk("sd_addr", sd_addr, e.addr);
                    if (e.chk_word)
                        chk("sd_wb_word", sd_dat_o[32*int'(e.idx) +: 32], e.word);
                end
                if (sd_we) mem[sd_addr] = sd_dat_o;
                else       sd_dat_i = mem.exists(sd_addr) ? mem[sd_addr] : make_block(sd_addr);
                sd_ack = 1'b1;
            end
        end else begin
            sd_cnt = 0;
        end
    end

    // SD card model for the SDSC instance.
    always @(negedge clk) begin
        if (!reset_n) begin
            sd1_ack = 1'b0;
            sd1_cnt = 0;
        end else if (sd1_ack) begin
            sd1_ack = 1'b0;
        end else if (sd1_cyc && sd1_stb) begin
            sd1_cnt++;
            if (sd1_cnt >= 2) begin
                sd1_cnt = 0;
                if (sd1_exp_q.size() == 0) chk("sdsc_unexpected_txn", sd1_addr, 32'hFFFF_FFFF);
                else                       chk("sdsc_addr", sd1_addr, sd1_exp_q.pop_front());
                sd1_dat_i = make_block(sd1_addr);
                sd1_ack   = 1'b1;
            end
        end else begin
            sd1_cnt = 0;
        end
    end

    // One CPU access held until ack; exp_lat = 0 skips the latency check.
    task automatic cpu_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [3:0] sel, input logic [31:0] wdat,
                              input logic [31:0] exp, input int exp_lat);
        int lat;
        logic [31:0] e;
        lat = 0;
        if (!we) rd_q.push_back(exp);
        @(negedge clk);
        cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = we;
        cpu_addr = addr; cpu_sel = sel; cpu_dat_i = wdat;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                lat = i;
                break;
            end
        end
        if (!we) e = rd_q.pop_front();
        chk({tag, "_acked"}, 32'(lat != 0), 32'd1);
        if (!we && lat != 0) chk({tag, "_data"}, cpu_dat_o, e);
        if (exp_lat > 0) chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_pulse"}, 32'(cpu_ack), 32'd0);
        chk({tag, "_sd_pending"}, 32'(sd_exp_q.size()), 32'd0);
    endtask

    task automatic do_flush(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        flush = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            flush = 1'b0;
            if (flush_done) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_done"}, 32'(lat != 0), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(flush_done), 32'd0);
        chk({tag, "_sd_pending"}, 32'(sd_exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4095:0] blk;
        int fd_at, ack_at, got;

        reset_n = 1'b0;
        cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; cpu_sel = 0; cpu_addr = 0; cpu_dat_i = 0; flush = 0;
        cpu1_cyc = 0; cpu1_stb = 0; cpu1_we = 0; cpu1_sel = 0; cpu1_addr = 0; cpu1_dat_i = 0; flush1 = 0;
        blk = make_block(32'h2);
        blk[63:32] = 32'hDEAD_BEEF;
        mem[32'h2] = blk;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_sd_cyc", 32'(sd_cyc), 32'd0);
        chk("rst_sd_stb", 32'(sd_stb), 32'd0);
        chk("rst_sd_we", 32'(sd_we), 32'd0);
        chk("rst_sd_addr", sd_addr, 32'd0);
        chk("rst_cpu_dat_o", cpu_dat_o, 32'd0);

        // Cold read miss fills block 2.
        exp_sd(1'b0, 32'h2, 1'b0, 7'd0, 32'd0);
        cpu_access("miss_rd", 1'b0, 32'h0000_0404, 4'hF, 32'd0, 32'hDEAD_BEEF, 0);

        // Hits: partial write then read back, no SD traffic.
        cpu_access("hit_wr", 1'b1, 32'h0000_0404, 4'b0011, 32'h1122_3344, 32'd0, 2);
        cpu_access("hit_rd", 1'b0, 32'h0000_0404, 4'hF, 32'd0, 32'hDEAD_3344, 2);

        // Dirty eviction: write back block 2, then fill block 4.
        exp_sd(1'b1, 32'h2, 1'b1, 7'd1, 32'hDEAD_3344);
        exp_sd(1'b0, 32'h4, 1'b0, 7'd0, 32'd0);
        cpu_access("evict_rd", 1'b0, 32'h0000_0800, 4'hF, 32'd0, 32'hC004_0000, 0);

        // Dirty the line, then flush and write together.
        cpu_access("dirty_wr", 1'b1, 32'h0000_0808, 4'hF, 32'hCAFE_F00D, 32'd0, 2);
        exp_sd(1'b1, 32'h4, 1'b1, 7'd2, 32'hCAFE_F00D);
        fd_at = 0; ack_at = 0;
        @(negedge clk);
        flush = 1'b1;
        cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b1;
        cpu_addr = 32'h0000_080C; cpu_sel = 4'hF; cpu_dat_i = 32'h1234_5678;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            flush = 1'b0;
            if (flush_done && fd_at == 0) fd_at = i;
            if (cpu_ack) begin
                ack_at = i;
                break;
            end
        end
        cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0;
        chk("fw_flush_done_seen", 32'(fd_at != 0), 32'd1);
        chk("fw_ack_seen", 32'(ack_at != 0), 32'd1);
        chk("fw_done_before_ack", 32'(fd_at != 0 && fd_at < ack_at), 32'd1);
        chk("fw_sd_pending", 32'(sd_exp_q.size()), 32'd0);

        // The merged write left the line dirty; flush it, then flush clean.
        exp_sd(1'b1, 32'h4, 1'b1, 7'd3, 32'h1234_5678);
        do_flush("flush_dirty", 3);
        do_flush("flush_clean", 1);

        // Clean miss re-reads block 2 as written back earlier.
        exp_sd(1'b0, 32'h2, 1'b0, 7'd0, 32'd0);
        cpu_access("refill_rd", 1'b0, 32'h0000_0404, 4'hF, 32'd0, 32'hDEAD_3344, 0);

        // SDSC instance uses byte addresses.
        sd1_exp_q.push_back(32'h0000_0A00);
        got = 0;
        @(negedge clk);
        cpu1_cyc = 1'b1; cpu1_stb = 1'b1; cpu1_addr = 32'h0000_0A10; cpu1_sel = 4'hF;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (cpu1_ack) begin
                got = 1;
                break;
            end
        end
        cpu1_cyc = 1'b0; cpu1_stb = 1'b0;
        chk("sdsc_acked", 32'(got), 32'd1);
        chk("sdsc_data", cpu1_dat_o, 32'hC000_0004);
        chk("sdsc_pending", 32'(sd1_exp_q.size()), 32'd0);

        // Reset while a fill is outstanding.
        sd_lat = 20;
        got = 0;
        @(negedge clk);
        cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0C00;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (sd_stb) begin
                got = 1;
                break;
            end
        end
        chk("rstfill_stb_seen", 32'(got), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstfill_sd_cyc", 32'(sd_cyc), 32'd0);
        chk("rstfill_sd_stb", 32'(sd_stb), 32'd0);
        cpu_cyc = 1'b0; cpu_stb = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sd_lat = 2;
        @(negedge clk);

        // Previously held block 2 must miss again after reset.
        exp_sd(1'b0, 32'h2, 1'b0, 7'd0, 32'd0);
        cpu_access("post_rst_rd", 1'b0, 32'h0000_0404, 4'hF, 32'd0, 32'hDEAD_3344, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sd_block_cache.md
Name: sd_block_cache

Overview:
- Single-line, write-back block buffer between the CPU-side 32-bit Wishbone bus and the SD controller's 512-byte block interface.
- Serves word reads and writes from a locally held 4096-bit block.
- Issues whole-block read (CMD17) and write (CMD24) transactions to the SD controller only on miss, eviction or flush.
- Sits directly upstream of the SD controller; its SD-side port is a Wishbone primary driving the controller's secondary.

Parameters:
- SDSC, 0: 1 means the controller expects byte addresses, so sd_addr = {tag, 9'b0}. 0 means block addresses (SDHC), so sd_addr = {9'b0, tag}.
- BLOCK_BITS, 4096: block width in bits. Fixed at 512 bytes; other values unsupported.

Ports:
- clock, input, 1: single clock.
- reset_n, input, 1: reset, asynchronous and active-low.
- cpu_cyc, input, 1: CPU Wishbone cycle.
- cpu_stb, input, 1: CPU Wishbone strobe.
- cpu_we, input, 1: 1 = write.
- cpu_sel, input, 4: byte-lane enables for writes.
- cpu_addr, input, 32: byte address. [31:9] = tag, [8:2] = word index, [1:0] ignored.
- cpu_dat_i, input, 32: write data.
- cpu_dat_o, output, 32: read data, valid when cpu_ack = 1.
- cpu_ack, output, 1: one-cycle acknowledge pulse.
- flush, input, 1: pulse; request write-back of a dirty line.
- flush_done, output, 1: one-cycle pulse when the flush completes.
- sd_cyc, output, 1: SD-side Wishbone cycle.
- sd_stb, output, 1: SD-side Wishbone strobe.
- sd_we, output, 1: 1 = block write (CMD24), 0 = block read (CMD17).
- sd_addr, output, 32: block or byte address per SDSC.
- sd_dat_o, output, 4096: block to write.
- sd_dat_i, input, 4096: block read from the card.
- sd_ack, input, 1: controller acknowledge, one-cycle pulse.

Behaviour:
- Reset (reset_n low, asynchronous) clears:
  - state to IDLE;
  - valid = 0, dirty = 0, tag = 0, line = 0;
  - cpu_ack, flush_done, sd_cyc, sd_stb, sd_we = 0;
  - sd_addr = 0, cpu_dat_o = 0.
- Reset mid-SD-transaction drops sd_cyc/sd_stb immediately. Line contents are lost; no write-back.
- State machine: IDLE, WRITEBACK, FILL, RESPOND, FLUSH.
- Request = cpu_cyc & cpu_stb. Hit = valid & (tag == cpu_addr[31:9]).
- IDLE, priorities:
  1. flush: if dirty, go to FLUSH. Else pulse flush_done next cycle and stay in IDLE.
  2. Request with hit: go to RESPOND.
  3. Request with miss and dirty: go to WRITEBACK.
  4. Request with miss and clean: go to FILL.
- A CPU request arriving together with flush is held (no ack) until the flush finishes.
- RESPOND (one cycle):
  - cpu_ack = 1.
  - Read: cpu_dat_o = line word [idx].
  - Write: each byte lane b with cpu_sel[b] = 1 takes cpu_dat_i byte b; dirty is set.
  - Next state IDLE.
  - Hit latency: ack is registered 2 cycles after stb is first sampled. The CPU must hold stb until ack; the block re-evaluates the request in IDLE.
- WRITEBACK / FLUSH:
  - sd_cyc = sd_stb = sd_we = 1; sd_addr from the current tag; sd_dat_o = line.
  - Held until sd_ack is sampled high.
  - Deasserted in the cycle after sd_ack, so the controller sees no second request.
  - On sd_ack: dirty = 0.
  - WRITEBACK then goes to FILL. FLUSH pulses flush_done and goes to IDLE.
- FILL:
  - sd_cyc = sd_stb = 1, sd_we = 0, sd_addr from cpu_addr[31:9].
  - On sd_ack: line = sd_dat_i, tag = cpu_addr[31:9], valid = 1, dirty = 0, then go to RESPOND.
  - A write miss is merged in RESPOND after the fill (write-allocate).
- CPU deasserts stb during a miss: the SD transaction still completes, the line is installed, then go to IDLE with no ack.
- Word index mapping: word i occupies line bits [32*i+31 : 32*i], for i = 0..127. This matches the controller's data ordering.
- sd_addr must be stable from the cycle sd_stb rises until sd_ack.

Decomposition:
- Shared package sd_pkg holds:
  - state enum typedef;
  - BlockBytes = 512, WordsPerBlock = 128, TagWidth = 23;
  - a function computing sd_addr from tag and SDSC.
- No sub-module; a single FSM plus line registers is sufficient.

Test Plan:
- Reset, then read 0x0000_0404:
  - FILL issues sd_addr = 0x2 (SDSC = 0) with sd_we = 0.
  - SD model returns word 1 = 0xDEADBEEF.
  - Required: cpu_dat_o = 0xDEADBEEF with one cpu_ack pulse; sd_stb drops the cycle after sd_ack.
- Hit path:
  - Write 0x0000_0404 = 0x11223344 with sel = 4'b0011.
  - Read back: required 0xDEAD3344.
  - No sd_stb activity during either access; cpu_ack 2 cycles after stb.
- Dirty eviction: after the hit-path write, read 0x0000_0800.
  - Required: a WRITEBACK to sd_addr = 0x2 with sd_dat_o word 1 = 0xDEAD3344.
  - Then a FILL of sd_addr = 0x4, then cpu_ack.
- SDSC = 1 instance, read 0x0000_0A10: required sd_addr = 0x0000_0A00.
- Flush and request together:
  - flush pulse in the same cycle as a write request, line dirty.
  - Required: FLUSH write-back completes and flush_done pulses before the CPU write is acked.
  - A second flush on the clean line gives flush_done the next cycle with no SD traffic.
- Reset during FILL:
  - Assert reset_n = 0 while sd_stb = 1.
  - Required: sd_cyc/sd_stb = 0 immediately.
  - After release, the old address misses again (valid = 0).
